mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 24 ++
 rtl/mem_arbiter_rr_pick.sv | 36 +++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_t       : arbiter FSM states
//   RD_LAT_DEF    : default cycles from read issue to valid memory data
//   WR_LAT_DEF    : default cycles a write occupies the memory after issue
//   PORT0/PORT1   : requester port indices (instruction / data cache)
//   CNT_W         : width of the latency wait counter
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  localparam int RD_LAT_DEF = 2;
  localparam int WR_LAT_DEF = 4;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rr_pick: 2-way round-robin selector with its own pointer register.
// The pointer names the favoured port; it resets to port 0 and, on each
// accepted grant, moves to the port that was not granted.
//   clk, rst : clock, asynchronous active-low reset
//   req      : request vector, bit i = port i
//   take     : arbiter is ready to accept a grant this cycle
//   valid    : at least one port is requesting
//   sel      : selected port index
module rr_pick
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       valid,
  output logic       sel
);

  logic ptr;

  assign valid = |req;
  // The favoured port wins if it requests; otherwise the other port does.
  assign sel   = req[ptr] ? ptr : ~ptr;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PORT0;
    end else if (take && valid) begin
      ptr <= ~sel;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates two cache controllers onto one banked memory.
// A requester is granted in IDLE, its operation is issued once the target
// bank (mem_addr[2:1]) is free, the fixed read/write latency is counted
// out, and a one-cycle ack with rdata/err is returned.
//   clk, rst                         : clock, asynchronous active-low reset
//   reqN_rd/wr/addr/wdata            : requester N command (held until ackN)
//   ackN, rdataN, errN               : requester N completion
//   mem_rd, mem_wr                   : one-cycle issue strobes
//   mem_addr, mem_wdata              : latched address / write data
//   mem_data_out, mem_busy, mem_err  : memory read data, bank busy, error
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int WR_LAT = WR_LAT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_rd,
  input  logic        req0_wr,
  input  logic [15:0] req0_addr,
  input  logic [15:0] req0_wdata,
  output logic        ack0,
  output logic [15:0] rdata0,
  output logic        err0,
  input  logic        req1_rd,
  input  logic        req1_wr,
  input  logic [15:0] req1_addr,
  input  logic [15:0] req1_wdata,
  output logic        ack1,
  output logic [15:0] rdata1,
  output logic        err1,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_data_out,
  input  logic [3:0]  mem_busy,
  input  logic        mem_err
);

  // Read: counter reaches 1 in cycle T+RD_LAT, where data is captured.
  // Write: counter reaches 1 in cycle T+WR_LAT-1, so RESP lands on T+WR_LAT.
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  state_t           state;
  logic             gnt;
  logic             op_rd;
  logic             op_wr;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;

  logic [1:0] req_vec;
  logic       pick_valid;
  logic       pick_sel;
  logic       op_bad;
  logic       bank_busy;
  logic       issue_go;
  logic       in_resp;

  assign req_vec = {req1_rd | req1_wr, req0_rd | req0_wr};

  rr_pick u_rr_pick (
    .clk   (clk),
    .rst   (rst),
    .req   (req_vec),
    .take  (state == ST_IDLE),
    .valid (pick_valid),
    .sel   (pick_sel)
  );

  // rd and wr together is an illegal command: it never touches memory.
  assign op_bad    = op_rd & op_wr;
  assign bank_busy = mem_busy[mem_addr[2:1]];

  // The strobes are decoded from the state register so they can react to
  // bank busy in the same cycle and pulse exactly in the issue cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    issue_go = 1'b0;
    if (state == ST_ISSUE && !op_bad && !bank_busy) begin
      issue_go = 1'b1;
    end
  end

  assign mem_rd  = issue_go & op_rd;
  assign mem_wr  = issue_go & op_wr;

  // Errors seen during the RESP cycle itself still count for this ack.
  assign in_resp = (state == ST_RESP);
  assign ack0    = in_resp && (gnt == PORT0);
  assign ack1    = in_resp && (gnt == PORT1);
  assign err0    = ack0 && (err_flag || mem_err);
  assign err1    = ack1 && (err_flag || mem_err);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      gnt       <= PORT0;
      op_rd     <= 1'b0;
      op_wr     <= 1'b0;
      cnt       <= '0;
      err_flag  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          err_flag <= 1'b0;
          cnt      <= '0;
          if (pick_valid) begin
            // Command is frozen here; requester changes are ignored until ack.
            gnt       <= pick_sel;
            op_rd     <= (pick_sel == PORT1) ? req1_rd    : req0_rd;
            op_wr     <= (pick_sel == PORT1) ? req1_wr    : req0_wr;
            mem_addr  <= (pick_sel == PORT1) ? req1_addr  : req0_addr;
            mem_wdata <= (pick_sel == PORT1) ? req1_wdata : req0_wdata;
            state     <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (op_bad) begin
            err_flag <= 1'b1;
            if (gnt == PORT1) rdata1 <= '0;
            else              rdata0 <= '0;
            state <= ST_RESP;
          end else if (!bank_busy) begin
            // This is issue cycle T; mem_err is already sampled from here on.
            err_flag <= err_flag | mem_err;
            if (op_rd) begin
              cnt   <= RD_LOAD;
              state <= ST_WAIT;
            end else if (WR_LOAD == '0) begin
              state <= ST_RESP;
            end else begin
              cnt   <= WR_LOAD;
              state <= ST_WAIT;
            end
          end
        end

        ST_WAIT: begin
          err_flag <= err_flag | mem_err;
          // Counter stops at the last wait cycle and never wraps below zero.
          if (cnt <= CNT_W'(1)) begin
            cnt <= '0;
            if (op_rd) begin
              if (gnt == PORT1) rdata1 <= mem_data_out;
              else              rdata0 <= mem_data_out;
            end
            state <= ST_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        ST_RESP: begin
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
